// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl -- program-load and run controller for the single-cycle MIPS core.
//
// Accepts a valid/ready stream of image words and steers each one into
// instruction or data memory through registered write ports. The core is held
// in reset while the image loads. After loading, the controller runs the core
// until it halts (PC stuck on a jump-to-self) or until a programmable cycle
// budget is used up.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   ld_valid/ld_ready     load handshake; ld_sel picks the memory (0 imem, 1 dmem),
//                         ld_addr/ld_data give the word, ld_last marks the end
//   run_limit             cycle budget, sampled on RUN entry (0 = unlimited)
//   imem_we/dmem_we       write strobes, at most one high, 1 cycle after handshake
//   mem_addr/mem_wdata    registered write address and data
//   cpu_rst               core reset (high outside RUN)
//   cpu_pc                core PC, watched for a halt
//   done/timeout          run finished / finished on budget rather than halt
//   cycle_cnt             RUN cycles elapsed (saturating)
module mips_run_ctrl #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int CYC_W       = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [CYC_W-1:0]  run_limit,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_cnt
);

  localparam int STALL_W = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    prev_pc;
  logic [STALL_W-1:0] stall_cnt;
  logic [CYC_W-1:0]   limit_q;

  logic               hs;
  logic [CYC_W-1:0]   cnt_inc;
  logic               pc_same;
  logic               halt_hit;
  logic               budget_hit;

  assign hs      = ld_valid & ld_ready;
  assign cnt_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;

  // prev_pc holds nothing meaningful during the first RUN cycle, so the
  // comparison is only trusted once at least one RUN cycle has been counted.
  assign pc_same    = (cycle_cnt != '0) && (cpu_pc == prev_pc);
  assign halt_hit   = pc_same && (stall_cnt == STALL_W'(HALT_REPEAT - 1));
  assign budget_hit = (limit_q != '0) && (cnt_inc == limit_q);

  // Outputs below are decoded from the state register alone, so no input
  // reaches an output combinationally.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    ld_ready  = 1'b0;
    cpu_rst   = 1'b1;
    done      = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (hs && ld_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: state_nxt = S_RUN;
      S_RUN: begin
        cpu_rst = 1'b0;
        if (halt_hit || budget_hit) state_nxt = S_DONE;
      end
      S_DONE: done = 1'b1;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= S_LOAD;
      imem_we   <= 1'b0;
      dmem_we   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      prev_pc   <= '0;
      limit_q   <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= hs & ~ld_sel;
      dmem_we <= hs & ld_sel;
      if (hs) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_data;
      end

      if (state == S_FLUSH) limit_q <= run_limit;

      if (state == S_RUN) begin
        cycle_cnt <= cnt_inc;
        prev_pc   <= cpu_pc;
        stall_cnt <= pc_same ? stall_cnt + 1'b1 : '0;
        // A halt on the same edge as the budget is reported as a clean halt.
        if (halt_hit)        timeout <= 1'b0;
        else if (budget_hit) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed testbench for mips_run_ctrl. A second instance with CYC_W=4 shares
// the stimulus and is only inspected for cycle-counter saturation.
module tb_mips_run_ctrl;

  logic        clk_tb = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_sel = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic [15:0] run_limit = '0;
  logic [31:0] cpu_pc = '0;

  logic        ld_ready, imem_we, dmem_we, cpu_rst, done, timeout;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] cycle_cnt;

  logic        ld_ready_4, imem_we_4, dmem_we_4, cpu_rst_4, done_4, timeout_4;
  logic [5:0]  mem_addr_4;
  logic [31:0] mem_wdata_4;
  logic [3:0]  cycle_cnt_4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_tb = ~clk_tb;

  mips_run_ctrl dut (
    .clk(clk_tb), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .run_limit(run_limit),
    .imem_we(imem_we), .dmem_we(dmem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .cpu_pc(cpu_pc),
    .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  mips_run_ctrl #(.CYC_W(4)) dut4 (
    .clk(clk_tb), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready_4), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .run_limit(run_limit[3:0]),
    .imem_we(imem_we_4), .dmem_we(dmem_we_4),
    .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4),
    .cpu_rst(cpu_rst_4), .cpu_pc(cpu_pc),
    .done(done_4), .timeout(timeout_4), .cycle_cnt(cycle_cnt_4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Load a single last word and step through FLUSH; returns in the first RUN cycle.
  task automatic load_and_start(input logic [15:0] lim);
    run_limit = lim;
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 32'h0; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    check("rst_ld_ready", ld_ready, 1);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_strobes", {imem_we, dmem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // ---------------- burst load imem words 0..3
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_sel = 1'b0;
      ld_addr = 6'(i); ld_data = 32'h11 * (i + 1); ld_last = (i == 3);
      tick();
      check($sformatf("burst_imem_we%0d", i), imem_we, 1);
      check($sformatf("burst_dmem_we%0d", i), dmem_we, 0);
      check($sformatf("burst_addr%0d", i), mem_addr, i);
      check($sformatf("burst_data%0d", i), mem_wdata, 32'h11 * (i + 1));
      check($sformatf("burst_cpu_rst%0d", i), cpu_rst, 1);
    end
    check("burst_ready_after_last", ld_ready, 0);
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check("burst_imem_we_off", imem_we, 0);
    check("burst_cpu_rst_fall", cpu_rst, 0);
    check("burst_ready_stays_low", ld_ready, 0);

    // ---------------- mixed stream with valid gaps
    do_reset();
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 6'd5; ld_data = 32'hDEADBEEF; ld_last = 1'b0;
    tick();
    check("mix_imem_pulse", {imem_we, dmem_we}, 2'b10);
    check("mix_imem_addr", mem_addr, 5);
    check("mix_imem_data", mem_wdata, 32'hDEADBEEF);
    ld_valid = 1'b0;
    tick();
    check("mix_idle1", {imem_we, dmem_we}, 2'b00);
    check("mix_idle1_ready", ld_ready, 1);
    tick();
    check("mix_idle2", {imem_we, dmem_we}, 2'b00);
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 6'd63; ld_data = 32'h1; ld_last = 1'b1;
    tick();
    check("mix_dmem_pulse", {imem_we, dmem_we}, 2'b01);
    check("mix_dmem_addr", mem_addr, 63);
    check("mix_dmem_data", mem_wdata, 1);
    check("mix_ready_low", ld_ready, 0);
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check("mix_after", {imem_we, dmem_we}, 2'b00);
    check("mix_running", cpu_rst, 0);

    // ---------------- halt: pc 0,4,8,8,8,8,8
    do_reset();
    load_and_start(16'd0);
    for (int k = 0; k < 7; k++) begin
      cpu_pc = (k < 2) ? 32'(4 * k) : 32'd8;
      tick();
      if (k == 5) check("halt_not_yet", done, 0);
    end
    check("halt_done", done, 1);
    check("halt_timeout", timeout, 0);
    check("halt_cycle_cnt", cycle_cnt, 7);
    check("halt_cpu_rst", cpu_rst, 1);
    ld_valid = 1'b1; ld_last = 1'b1; cpu_pc = 32'd100;
    tick();
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("halt_frozen_cnt", cycle_cnt, 7);
    check("halt_frozen_done", done, 1);
    check("halt_ignores_load", {ld_ready, imem_we, dmem_we}, 3'b000);

    // ---------------- budget: limit 10, pc incrementing
    do_reset();
    load_and_start(16'd10);
    for (int k = 0; k < 10; k++) begin
      cpu_pc = 32'(4 * k);
      tick();
      if (k == 8) check("budget_not_yet", done, 0);
    end
    check("budget_done", done, 1);
    check("budget_timeout", timeout, 1);
    check("budget_cycle_cnt", cycle_cnt, 10);

    // ---------------- halt and budget on the same (10th) edge
    do_reset();
    load_and_start(16'd10);
    for (int k = 0; k < 10; k++) begin
      cpu_pc = (k < 5) ? 32'(4 * k) : 32'd20;
      tick();
    end
    check("tie_done", done, 1);
    check("tie_timeout", timeout, 0);
    check("tie_cycle_cnt", cycle_cnt, 10);

    // ---------------- rst in the middle of RUN, then reload
    do_reset();
    load_and_start(16'd0);
    for (int k = 0; k < 5; k++) begin
      cpu_pc = 32'(4 * k);
      tick();
    end
    check("midrst_precnt", cycle_cnt, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", ld_ready, 1);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_done", done, 0);
    check("midrst_cycle_cnt", cycle_cnt, 0);
    load_and_start(16'd3);
    check("reload_running", cpu_rst, 0);
    for (int k = 0; k < 3; k++) begin
      cpu_pc = 32'(4 * k);
      tick();
    end
    check("reload_done", done, 1);
    check("reload_timeout", timeout, 1);
    check("reload_cycle_cnt", cycle_cnt, 3);

    // ---------------- unlimited run, 1000 cycles, never repeating pc
    do_reset();
    load_and_start(16'd0);
    for (int k = 0; k < 1000; k++) begin
      cpu_pc = 32'(4 * k);
      tick();
    end
    check("long_done", done, 0);
    check("long_cpu_rst", cpu_rst, 0);
    check("long_cycle_cnt", cycle_cnt, 1000);
    check("sat4_cycle_cnt", cycle_cnt_4, 15);
    check("sat4_done", done_4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Synthesisable program-load and run controller for the single-cycle MIPS core, replacing bench-side backdoor memory preloads and fixed-length runs. It accepts a valid/ready stream of words, steers each into instruction or data memory, holds the core in reset until loading completes, then runs the core. A run ends on a halt (PC stuck on a jump-to-self) or on a programmable cycle budget, and the controller reports done, timeout and cycle count.

## Interface
- ADDR_W, 6, word-address width of both memories (depth 2^ADDR_W)
- DATA_W, 32, memory word width
- PC_W, 32, core PC width
- CYC_W, 16, cycle counter and limit width
- HALT_REPEAT, 4, consecutive repeated-PC cycles that declare a halt (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted when ld_valid & ld_ready
- ld_sel  in  1  target: 0 = instruction mem, 1 = data mem
- ld_addr  in  ADDR_W  word address
- ld_data  in  DATA_W  word
- ld_last  in  1  final word of image
- run_limit  in  CYC_W  cycle budget, sampled on RUN entry; 0 = unlimited
- imem_we / dmem_we  out  1  write strobes, one-hot or both 0
- mem_addr  out  ADDR_W  registered write address
- mem_wdata  out  DATA_W  registered write data
- cpu_rst  out  1  core reset, active-high
- cpu_pc  in  PC_W  core PC
- done  out  1  run finished
- timeout  out  1  run ended on budget, not halt
- cycle_cnt  out  CYC_W  RUN cycles elapsed

## Operation
- States: LOAD (reset state) → FLUSH → RUN → DONE. DONE is left only by rst.
- Reset values: state LOAD, ld_ready 1, imem_we/dmem_we 0, mem_addr/mem_wdata 0, cpu_rst 1, done 0, timeout 0, cycle_cnt 0, stall counter 0.
- LOAD: ld_ready=1, cpu_rst=1. On a handshake, register addr/data and assert exactly one strobe, chosen by ld_sel, for the following cycle only. No handshake means no strobe. Back-to-back handshakes give back-to-back strobes.
- A handshake with ld_last=1 moves the state to FLUSH. ld_ready is 0 from that point until rst.
- FLUSH: one cycle. The final write strobe fires here and cpu_rst stays 1. The controller then captures run_limit and enters RUN.
- RUN: cpu_rst=0. Each RUN cycle, cycle_cnt increments, saturating at 2^CYC_W-1. prev_pc is registered each cycle.
  - From the second RUN cycle on, the stall counter increments when cpu_pc == prev_pc and clears otherwise.
- Halt: if the stall counter would reach HALT_REPEAT at an edge, go to DONE with done=1 and timeout=0.
- Budget: if run_limit≠0 and the incremented cycle_cnt equals run_limit at an edge, go to DONE with done=1 and timeout=1.
- Halt and budget at the same edge: halt wins, timeout=0.
- DONE: cpu_rst=1. done, timeout and cycle_cnt are frozen. Load inputs are ignored.
- rst in any state, including mid-LOAD or mid-RUN, restores all reset values at the next edge. Memory contents are not cleared.

## Timing
- Write latency: strobe, addr and data appear 1 cycle after the handshake edge.
- cpu_rst falls 2 edges after the last-word handshake edge (LOAD→FLUSH→RUN).
- done/timeout rise at the edge ending the deciding RUN cycle. cycle_cnt then equals the number of RUN cycles executed.
- cpu_pc is sampled every RUN cycle. No combinational path exists from any input to any output.

## Test plan
- Load imem words 0..3 (data 0x11..0x44), ld_valid held high, ld_last on word 3 -> imem_we high for 4 consecutive cycles starting 1 cycle after the first handshake; mem_addr 0..3; ld_ready 0 after the 4th handshake; cpu_rst falls 2 cycles after it.
- Mixed stream with valid gaps: imem@5=0xDEADBEEF, idle 2 cycles, dmem@63=0x00000001 last -> one imem_we pulse, then one dmem_we pulse with mem_addr 63; never both strobes high.
- Halt: HALT_REPEAT=4, run_limit=0, cpu_pc over RUN cycles 0,4,8,8,8,8,8 -> done=1 and timeout=0 after the 7th RUN cycle; cycle_cnt=7; cpu_rst=1.
- Budget: run_limit=10, cpu_pc incrementing by 4 -> done=1, timeout=1, cycle_cnt=10. Repeat with the halt condition landing on the 10th cycle -> timeout=0.
- rst asserted for 1 cycle at RUN cycle 5 -> next cycle state LOAD, ld_ready=1, cpu_rst=1, done=0, cycle_cnt=0; a reload then runs normally.
- run_limit=0, cpu_pc never repeats, 1000 cycles -> done stays 0. With CYC_W=4, cycle_cnt saturates at 15.
